// File: rtl/pmu_mode_requester.sv
// Host-side mode request sequencer in front of the PMU: registers mode/mode_req, waits for
// mode_ack with a timeout and reports done or a sticky timeout error.
module pmu_mode_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 32,
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic host_req_valid,
  input  logic host_req_mode,
  output logic host_req_ready,
  input  logic err_clear,
  input  logic mode_ack,
  output logic mode,
  output logic mode_req,
  output logic busy,
  output logic done,
  output logic err_timeout,
  output logic cur_mode
);

  typedef enum logic [1:0] {StIdle, StReq, StDone, StError} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             mode_req_q, mode_req_d;
  logic             cur_mode_q, cur_mode_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic accept, noop, expired;

  assign accept  = host_req_valid && (state_q == StIdle);
  assign noop    = (host_req_mode == cur_mode_q);
  assign expired = (cnt_q == CntLast);

  // State and registered outputs; mode resets to full power.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      mode_q     <= 1'b1;
      mode_req_q <= 1'b0;
      cur_mode_q <= 1'b1;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      mode_req_q <= mode_req_d;
      cur_mode_q <= cur_mode_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = noop ? StDone : StReq;
      end
      StReq: begin
        // An ack in the expiry cycle takes priority over the timeout.
        if (mode_ack)     state_d = StDone;
        else if (expired) state_d = StError;
      end
      StDone:  state_d = StIdle;
      StError: begin
        if (err_clear) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mode_d     = mode_q;
    mode_req_d = mode_req_q;
    cnt_d      = cnt_q;
    cur_mode_d = cur_mode_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept && !noop) begin
          mode_d     = host_req_mode;
          mode_req_d = 1'b1;
          cnt_d      = '0;
        end
      end
      StReq: begin
        // Leaving REQ at CntLast keeps the counter from wrapping.
        cnt_d = cnt_q + 1'b1;
        if (mode_ack) begin
          mode_req_d = 1'b0;
          cur_mode_d = mode_q;
        end else if (expired) begin
          mode_req_d = 1'b0;
          err_d      = 1'b1;
        end
      end
      StError: begin
        // mode is left at the requested value; the PMU may still be mid-sequence.
        if (err_clear) err_d = 1'b0;
      end
      default: ;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  assign host_req_ready = (state_q == StIdle);
  assign mode           = mode_q;
  assign mode_req       = mode_req_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_timeout    = err_q;
  assign cur_mode       = cur_mode_q;

  a_mode_stable: assert property (@(posedge clk) disable iff (!reset_n)
    mode_req |=> $stable(mode));
  a_done_pulse: assert property (@(posedge clk) disable iff (!reset_n)
    done |=> !done);
  a_done_no_req: assert property (@(posedge clk) disable iff (!reset_n)
    !(done && mode_req));
  a_ready_idle: assert property (@(posedge clk) disable iff (!reset_n)
    host_req_ready |-> !busy);
  a_cnt_bound: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == StReq) |-> (cnt_q <= CntLast));

endmodule
